// File: rtl/sweep_pkg.sv
// Shared types and sizes for the truth-table sweeper.
package sweep_pkg;

   localparam int NUM_VEC  = 64;
   localparam int IDX_W    = 6;
   localparam int SETTLE_W = 4;
   localparam int CNT_W    = 7;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_APPLY  = 2'd1,
      ST_SAMPLE = 2'd2,
      ST_DONE   = 2'd3
   } state_t;

endpackage

// File: rtl/truth_table_sweeper_if.sv
// Control, stimulus and result bundle between the sweeper and its user.
interface truth_table_sweeper_if;
   import sweep_pkg::*;

   logic                start;
   logic                abort;
   logic [NUM_VEC-1:0]  expected;
   logic                A, B, C, D, E, F;
   logic                Y;
   logic                busy;
   logic                done;
   logic [NUM_VEC-1:0]  table_out;
   logic                mismatch;
   logic [CNT_W-1:0]    mismatch_count;
   logic [IDX_W-1:0]    first_fail;

   modport master (
      output start, abort, expected, Y,
      input  A, B, C, D, E, F,
      input  busy, done, table_out,
      input  mismatch, mismatch_count, first_fail
   );

   modport slave (
      input  start, abort, expected, Y,
      output A, B, C, D, E, F,
      output busy, done, table_out,
      output mismatch, mismatch_count, first_fail
   );

endinterface

// File: rtl/sweep_counter.sv
// Settle down-counter and vector index up-counter for the sweeper.
module sweep_counter
   import sweep_pkg::*;
#(
   parameter int SETTLE = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_clear,
   input  logic             i_dec,
   input  logic             i_next,
   output logic [IDX_W-1:0] o_idx,
   output logic             o_settle_done,
   output logic             o_last
);

   localparam logic [SETTLE_W-1:0] LP_RELOAD = SETTLE_W'(SETTLE - 1);
   localparam logic [IDX_W-1:0]    LP_LAST   = IDX_W'(NUM_VEC - 1);

   logic [SETTLE_W-1:0] r_settle;
   logic [IDX_W-1:0]    r_idx;

   // Reload makes APPLY last exactly SETTLE cycles per vector.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_settle <= '0;
         r_idx    <= '0;
      end else if (i_clear) begin
         r_settle <= LP_RELOAD;
         r_idx    <= '0;
      end else if (i_next) begin
         r_settle <= LP_RELOAD;
         r_idx    <= r_idx + 1'b1;
      end else if (i_dec && r_settle != '0) begin
         r_settle <= r_settle - 1'b1;
      end
   end

   assign o_idx         = r_idx;
   assign o_settle_done = (r_settle == '0);
   assign o_last        = (r_idx == LP_LAST);

endmodule

// File: rtl/truth_table_sweeper.sv
// Walks all 64 input vectors of a 6-input unit and captures its truth table.
module truth_table_sweeper
   import sweep_pkg::*;
#(
   parameter int SETTLE = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   truth_table_sweeper_if.slave  sw
);

   state_t              r_state;
   state_t              w_next;
   logic [IDX_W-1:0]    w_idx;
   logic                w_settle_done;
   logic                w_last;
   logic                w_clear;
   logic                w_dec;
   logic                w_sample;
   logic                w_next_vec;
   logic                w_drive;
   logic                w_done;
   logic                w_fail;
   logic [NUM_VEC-1:0]  r_table;
   logic                r_mm;
   logic [CNT_W-1:0]    r_cnt;
   logic [IDX_W-1:0]    r_ff;

   assign w_clear    = (r_state == ST_IDLE) & sw.start & ~sw.abort;
   assign w_dec      = (r_state == ST_APPLY);
   assign w_sample   = (r_state == ST_SAMPLE) & ~sw.abort;
   assign w_next_vec = w_sample & ~w_last;
   assign w_fail     = sw.Y ^ sw.expected[w_idx];

   sweep_counter #(
      .SETTLE (SETTLE)
   ) u_cnt (
      .clk           (clk),
      .rst           (rst),
      .i_clear       (w_clear),
      .i_dec         (w_dec),
      .i_next        (w_next_vec),
      .o_idx         (w_idx),
      .o_settle_done (w_settle_done),
      .o_last        (w_last)
   );

   always_ff @(posedge clk) begin
      if (rst) r_state <= ST_IDLE;
      else     r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      unique case (r_state)
         ST_IDLE: begin
            if (sw.start && !sw.abort) w_next = ST_APPLY;
         end
         ST_APPLY: begin
            if (sw.abort)          w_next = ST_IDLE;
            else if (w_settle_done) w_next = ST_SAMPLE;
         end
         ST_SAMPLE: begin
            if (sw.abort)   w_next = ST_IDLE;
            else if (w_last) w_next = ST_DONE;
            else             w_next = ST_APPLY;
         end
         ST_DONE: w_next = ST_IDLE;
         default: w_next = ST_IDLE;
      endcase
   end

   always_comb begin
      w_drive = 1'b0;
      w_done  = 1'b0;
      unique case (r_state)
         ST_APPLY, ST_SAMPLE: w_drive = 1'b1;
         ST_DONE:             w_done  = 1'b1;
         default: ;
      endcase
   end

   // Results only change on a recorded sample; abort leaves them intact.
   always_ff @(posedge clk) begin
      if (rst || w_clear) begin
         r_table <= '0;
         r_mm    <= 1'b0;
         r_cnt   <= '0;
         r_ff    <= '0;
      end else if (w_sample) begin
         r_table[w_idx] <= sw.Y;
         if (w_fail) begin
            r_cnt <= r_cnt + 1'b1;
            r_mm  <= 1'b1;
            if (!r_mm) r_ff <= w_idx;
         end
      end
   end

   assign {sw.A, sw.B, sw.C, sw.D, sw.E, sw.F} = w_drive ? w_idx : '0;
   assign sw.busy           = w_drive;
   assign sw.done           = w_done;
   assign sw.table_out      = r_table;
   assign sw.mismatch       = r_mm;
   assign sw.mismatch_count = r_cnt;
   assign sw.first_fail     = r_ff;

endmodule

// File: doc/truth_table_sweeper.md
TRUTH_TABLE_SWEEPER -- requirements
Module: truth_table_sweeper

Interface
REQ-001 The block SHALL have parameter SETTLE, default 1, giving the cycles a vector is held before Y is sampled (legal range 1..15).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all logic is on the rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 The block SHALL have port start, input, 1 bit: sweep request, sampled in IDLE only.
REQ-005 The block SHALL have port abort, input, 1 bit: terminate the sweep in progress.
REQ-006 The block SHALL have port expected, input, 64 bits: golden truth table, bit i = expected Y for vector i; sampled each SAMPLE cycle.
REQ-007 The block SHALL have ports A, B, C, D, E, F, outputs, 1 bit each: drive the 6-input function unit under control; {A,B,C,D,E,F} = vector index, A = MSB.
REQ-008 The block SHALL have port Y, input, 1 bit: function unit output.
REQ-009 The block SHALL have port busy, output, 1 bit: high while a sweep is in progress.
REQ-010 The block SHALL have port done, output, 1 bit: one-cycle pulse on sweep completion.
REQ-011 The block SHALL have port table_out, output, 64 bits: captured truth table, bit i = Y sampled for vector i.
REQ-012 The block SHALL have port mismatch, output, 1 bit: at least one bit of table_out differs from expected.
REQ-013 The block SHALL have port mismatch_count, output, 7 bits: number of differing bits, 0..64.
REQ-014 The block SHALL have port first_fail, output, 6 bits: lowest failing index; 0 when mismatch=0.

Function
REQ-015 The FSM SHALL have states IDLE, APPLY, SAMPLE, DONE.
REQ-016 In IDLE with start=1 and abort=0, the FSM SHALL go to APPLY, clear idx, table_out, mismatch, mismatch_count and first_fail, and set busy=1 the next cycle.
REQ-017 In APPLY, A..F SHALL drive idx; after SETTLE cycles in APPLY, the FSM SHALL go to SAMPLE.
REQ-018 In SAMPLE, the block SHALL write Y into table_out[idx]; if Y != expected[idx], it SHALL increment mismatch_count, set mismatch, and load first_fail=idx if this is the first failure.
REQ-019 From SAMPLE: if idx<63, idx SHALL increment and the FSM SHALL return to APPLY; if idx=63, the FSM SHALL go to DONE (no wrap).
REQ-020 In DONE, done=1 and busy=0 for exactly one cycle, then the FSM SHALL return to IDLE.
REQ-021 Timing: with start accepted at edge k, vector i SHALL be driven from cycle k+1+i*(SETTLE+1), and done SHALL be high in cycle k+1+64*(SETTLE+1).
REQ-022 A..F SHALL be 0 in IDLE and DONE.
REQ-023 Results SHALL hold until the next accepted start.
REQ-024 start while busy SHALL be ignored, with no queuing.
REQ-025 abort=1 in APPLY or SAMPLE SHALL return the FSM to IDLE next cycle: busy=0, no done, and A..F=0. The partial table_out and count SHALL be retained. A SAMPLE coinciding with abort SHALL NOT be recorded.
REQ-026 start and abort both high in IDLE: abort SHALL win and the FSM SHALL remain in IDLE.
REQ-027 Y SHALL be sampled only in SAMPLE and ignored otherwise.

Reset
REQ-028 rst SHALL force IDLE, idx=0, settle counter=0, A..F=0, busy=0, done=0, table_out=0, mismatch=0, mismatch_count=0 and first_fail=0 on the next edge, including mid-sweep.
REQ-029 rst SHALL override start and abort.

Structure
REQ-030 The state encoding, vector count (64), and counter widths SHALL be defined in shared package sweep_pkg.
REQ-031 The settle counter plus vector index SHALL be one sub-module, sweep_counter (settle down-count, idx up-count, last flag).
REQ-032 No combinational path SHALL exist from Y to any output.

Verification
REQ-033 SETTLE=1, Y tied 0, expected=0, start at edge k: the bench SHALL check done at cycle k+129, table_out=0, mismatch=0, count=0, first_fail=0.
REQ-034 Bench model Y=A&B, expected=64'hFFFF_0000_0000_0000: the bench SHALL check table_out equals expected and mismatch=0.
REQ-035 Same model, expected=0: the bench SHALL check mismatch=1, mismatch_count=16, first_fail=48.
REQ-036 abort during vector 10: the bench SHALL check busy=0 the next cycle, no done, A..F=0, table_out bits above 9 =0; a restart SHALL begin at vector 0.
REQ-037 start pulsed mid-sweep: the bench SHALL check it is ignored and done timing is unchanged; rst at vector 30 SHALL zero all outputs the next cycle.
REQ-038 SETTLE=3: the bench SHALL check each vector is held 4 cycles and done arrives at k+257.
